glip_sync_fifo: RTL and testbench

Single-clock, parametrised FIFO: the same-clock successor to the GLIP CDC FIFO, used wherever producer and consumer share a clock (JTAG backend packet buffering, logic-side staging). It adds arbitrary (non-power-of-two) depth, a first-word-fall-through (FWFT) mode, a fill-level output, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.

---
 rtl/glip_sync_fifo_if.sv | 29 ++
 rtl/glip_sync_fifo.sv | 117 +++++++++++
 tb/tb_glip_sync_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/glip_sync_fifo_if.sv
// rtl/glip_sync_fifo_if.sv - write/read handshake and status bundle of the single-clock FIFO
interface glip_sync_fifo_if #(
    parameter int DW = 32,
    parameter int LW = 5
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    // Producer/consumer side: drives requests, observes data and status
    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/glip_sync_fifo.sv
// rtl/glip_sync_fifo.sv - single-clock FIFO, any depth, optional FWFT, level and sticky error flags
module glip_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int FWFT  = 0,
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 1,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    glip_sync_fifo_if.slave fifo
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_next;
    logic          full_q;
    logic          empty_q;
    logic          af_q;
    logic          ae_q;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_acc;
    logic          rd_acc;

    // Acceptance looks only at registered flags, so a read freeing a slot
    // never lets a same-cycle write into a full FIFO.
    assign wr_acc = fifo.wr_en && !full_q;
    assign rd_acc = fifo.rd_en && !empty_q;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next fill level; simultaneous write and read cancel out.
    always_comb begin
        level_next = level_q;
        if (wr_acc && !rd_acc) begin
            level_next = level_q + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_next = level_q - LW'(1);
        end
    end

    // Storage array; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= fifo.wr_data;
        end
    end

    // Pointers, level, registered flags derived from next level, sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level_q <= level_next;
            full_q  <= (level_next == LW'(DEPTH));
            empty_q <= (level_next == '0);
            af_q    <= (level_next >= LW'(AF_TH));
            ae_q    <= (level_next <= LW'(AE_TH));
            if (fifo.wr_en && full_q) begin
                ovf_q <= 1'b1;
            end
            if (fifo.rd_en && empty_q) begin
                unf_q <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always presented; valid whenever not empty.
            assign fifo.rd_data = mem[rd_ptr];
        end else begin : g_std
            logic [DW-1:0] rd_q;

            // Output register loads only on an accepted read, otherwise holds.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[rd_ptr];
                end
            end

            assign fifo.rd_data = rd_q;
        end
    endgenerate

    assign fifo.full         = full_q;
    assign fifo.empty        = empty_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.level        = level_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_glip_sync_fifo.sv
// tb/tb_glip_sync_fifo.sv - self-checking bench for glip_sync_fifo in standard and FWFT modes
module tb_glip_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int LW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glip_sync_fifo_if #(.DW(DW), .LW(LW)) bs ();
    glip_sync_fifo_if #(.DW(DW), .LW(LW)) bf ();

    glip_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .FWFT(0), .AF_TH(4), .AE_TH(1)) u_std (
        .clk(clk), .rst_n(rst_n), .fifo(bs.slave)
    );
    glip_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .FWFT(1), .AF_TH(4), .AE_TH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .fifo(bf.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] qs[$];
    logic [7:0] qf[$];
    logic [7:0] exp_rd_s;
    bit ovf_s, unf_s, ovf_f, unf_f;

    logic [8:0] st_s;
    logic [8:0] st_f;
    assign st_s = {bs.level, bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow};
    assign st_f = {bf.level, bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow};

    // Expected status from entry count: {level, full, empty, af(>=4), ae(<=1), ovf, unf}
    function automatic logic [8:0] want(input int n, input bit o, input bit u);
        return {3'(n), n == DEPTH, n == 0, n >= 4, n <= 1, o, u};
    endfunction

    task automatic step(input bit ws, input logic [7:0] ds, input bit rs,
                        input bit wf, input logic [7:0] df, input bit rf);
        bit wa, ra;
        bs.wr_en = ws; bs.wr_data = ds; bs.rd_en = rs;
        bf.wr_en = wf; bf.wr_data = df; bf.rd_en = rf;
        wa = ws && (qs.size() < DEPTH);
        ra = rs && (qs.size() > 0);
        if (ws && !wa) ovf_s = 1'b1;
        if (rs && !ra) unf_s = 1'b1;
        if (ra) exp_rd_s = qs.pop_front();
        if (wa) qs.push_back(ds);
        wa = wf && (qf.size() < DEPTH);
        ra = rf && (qf.size() > 0);
        if (wf && !wa) ovf_f = 1'b1;
        if (rf && !ra) unf_f = 1'b1;
        if (ra) void'(qf.pop_front());
        if (wa) qf.push_back(df);
        @(posedge clk);
        #1;
        bs.wr_en = 1'b0; bs.rd_en = 1'b0;
        bf.wr_en = 1'b0; bf.rd_en = 1'b0;
    endtask

    // Reset with requests active to show reset overrides them.
    task automatic do_reset();
        rst_n = 1'b0;
        bs.wr_en = 1'b1; bs.rd_en = 1'b1; bs.wr_data = 8'hEE;
        bf.wr_en = 1'b1; bf.rd_en = 1'b1; bf.wr_data = 8'hEE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bs.wr_en = 1'b0; bs.rd_en = 1'b0;
        bf.wr_en = 1'b0; bf.rd_en = 1'b0;
        qs.delete(); qf.delete();
        exp_rd_s = 8'h00;
        ovf_s = 1'b0; unf_s = 1'b0; ovf_f = 1'b0; unf_f = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (st_s !== want(0, 0, 0)) begin bad++; $display("FAIL reset_std_status: got %h want %h", st_s, want(0, 0, 0)); end
        total++; if (st_f !== want(0, 0, 0)) begin bad++; $display("FAIL reset_fwft_status: got %h want %h", st_f, want(0, 0, 0)); end
        total++; if (bs.rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", bs.rd_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 8'h00, 1'b0);
            total++; if (st_s !== want(qs.size(), ovf_s, unf_s)) begin bad++; $display("FAIL fill_status[%0d]: got %h want %h", i, st_s, want(qs.size(), ovf_s, unf_s)); end
        end
        step(1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0);
        total++; if (st_s !== want(5, 1, 0)) begin bad++; $display("FAIL fill_overflow: got %h want %h", st_s, want(5, 1, 0)); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
            total++; if (bs.rd_data !== 8'(8'h11 * (i + 1))) begin bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, bs.rd_data, 8'(8'h11 * (i + 1))); end
            total++; if (st_s !== want(qs.size(), ovf_s, unf_s)) begin bad++; $display("FAIL drain_status[%0d]: got %h want %h", i, st_s, want(qs.size(), ovf_s, unf_s)); end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (bs.rd_data !== 8'h55) begin bad++; $display("FAIL drain_hold: got %h want 55", bs.rd_data); end
        total++; if (st_s !== want(0, 1, 1)) begin bad++; $display("FAIL drain_underflow: got %h want %h", st_s, want(0, 1, 1)); end
    endtask

    task automatic test_fwft();
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
        total++; if (bf.empty !== 1'b0 || bf.rd_data !== 8'hA5) begin bad++; $display("FAIL fwft_fallthrough: got empty=%b data=%h want empty=0 data=a5", bf.empty, bf.rd_data); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        total++; if (bf.empty !== 1'b1 || bf.level !== 3'd0) begin bad++; $display("FAIL fwft_pop: got empty=%b level=%0d want empty=1 level=0", bf.empty, bf.level); end
    endtask

    task automatic test_wrap();
        step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 8'h00, 1'b0);
            total++; if (bs.rd_data !== exp_rd_s) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bs.rd_data, exp_rd_s); end
            total++; if (st_s !== want(2, ovf_s, unf_s)) begin bad++; $display("FAIL wrap_status[%0d]: got %h want %h", i, st_s, want(2, ovf_s, unf_s)); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
            total++; if (bs.rd_data !== exp_rd_s) begin bad++; $display("FAIL wrap_tail[%0d]: got %h want %h", i, bs.rd_data, exp_rd_s); end
        end
    endtask

    task automatic test_simul_edges();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (bs.level !== 3'd4 || bs.overflow !== 1'b1 || bs.rd_data !== 8'h20) begin bad++; $display("FAIL simul_full: got level=%0d ovf=%b data=%h want level=4 ovf=1 data=20", bs.level, bs.overflow, bs.rd_data); end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h88, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (bs.level !== 3'd1 || bs.underflow !== 1'b1 || bs.rd_data !== 8'h24) begin bad++; $display("FAIL simul_empty: got level=%0d unf=%b data=%h want level=1 unf=1 data=24", bs.level, bs.underflow, bs.rd_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (bs.rd_data !== 8'h88) begin bad++; $display("FAIL simul_empty_data: got %h want 88", bs.rd_data); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (st_s !== want(3, 1, 0)) begin bad++; $display("FAIL pre_reset_status: got %h want %h", st_s, want(3, 1, 0)); end
        do_reset();
        total++; if (st_s !== want(0, 0, 0) || bs.rd_data !== 8'h00) begin bad++; $display("FAIL mid_reset: got status=%h data=%h want status=%h data=00", st_s, bs.rd_data, want(0, 0, 0)); end
        step(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (bs.rd_data !== 8'h3C || st_s !== want(0, 0, 0)) begin bad++; $display("FAIL post_reset_rw: got data=%h status=%h want data=3c status=%h", bs.rd_data, st_s, want(0, 0, 0)); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            total++; if (st_s !== want(qs.size(), ovf_s, unf_s)) begin bad++; $display("FAIL rand_std_status[%0d]: got %h want %h", i, st_s, want(qs.size(), ovf_s, unf_s)); end
            total++; if (bs.rd_data !== exp_rd_s) begin bad++; $display("FAIL rand_std_data[%0d]: got %h want %h", i, bs.rd_data, exp_rd_s); end
            total++; if (st_f !== want(qf.size(), ovf_f, unf_f)) begin bad++; $display("FAIL rand_fwft_status[%0d]: got %h want %h", i, st_f, want(qf.size(), ovf_f, unf_f)); end
            if (qf.size() > 0) begin
                total++; if (bf.rd_data !== qf[0]) begin bad++; $display("FAIL rand_fwft_head[%0d]: got %h want %h", i, bf.rd_data, qf[0]); end
            end
        end
    endtask

    initial begin
        bs.wr_en = 1'b0; bs.rd_en = 1'b0; bs.wr_data = 8'h00;
        bf.wr_en = 1'b0; bf.rd_en = 1'b0; bf.wr_data = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_wrap();
        test_simul_edges();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
